regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 37 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: two write ports, two read ports, issue marking and scoreboard status.
// The parameters must match the ones used for the regfile_sb instance.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              stall_req;
    logic [DEPTH-1:0]  busy_vec;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output re1, raddr1, re2, raddr2, iss_en, iss_addr,
        input  rdata1, rdata2, stall_req, busy_vec
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  re1, raddr1, re2, raddr2, iss_en, iss_addr,
        output rdata1, rdata2, stall_req, busy_vec
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-write / two-read register file with zero-latency write bypass and a
// per-register busy scoreboard that raises stall_req on unresolved operands.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr0;
    logic              wr1;
    logic              stall1;
    logic              stall2;

    // Read priority: address 0 and disabled ports read zero, then the WB port, then the LLU port.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              en,
        input logic [ADDR_W-1:0] a,
        input logic              w0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              w1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = stored;
        if (a == '0 || !en) r = '0;
        else if (w0 && a0 == a) r = d0;
        else if (w1 && a1 == a) r = d1;
        return r;
    endfunction

    function automatic logic wr_hit(
        input logic [ADDR_W-1:0] a,
        input logic              w0,
        input logic [ADDR_W-1:0] a0,
        input logic              w1,
        input logic [ADDR_W-1:0] a1
    );
        return (w0 && a0 == a) || (w1 && a1 == a);
    endfunction

    // Port 1 loses a same-address collision with port 0.
    assign wr0 = rf.we0 && (rf.waddr0 != '0);
    assign wr1 = rf.we1 && (rf.waddr1 != '0) && !(wr0 && (rf.waddr1 == rf.waddr0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr1) regs[rf.waddr1] <= rf.wdata1;
            if (wr0) regs[rf.waddr0] <= rf.wdata0;
            busy <= busy_nxt;
        end
    end

    // A new issue to the same register overrides the completing write's clear.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < DEPTH; i++) begin
            if (wr_hit(ADDR_W'(i), rf.we0, rf.waddr0, rf.we1, rf.waddr1)) busy_nxt[i] = 1'b0;
            if (rf.iss_en && (rf.iss_addr == ADDR_W'(i))) busy_nxt[i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign stall1 = rf.re1 && (rf.raddr1 != '0) && busy[rf.raddr1] &&
                    !wr_hit(rf.raddr1, rf.we0, rf.waddr0, rf.we1, rf.waddr1);
    assign stall2 = rf.re2 && (rf.raddr2 != '0) && busy[rf.raddr2] &&
                    !wr_hit(rf.raddr2, rf.we0, rf.waddr0, rf.we1, rf.waddr1);

    assign rf.stall_req = !rst && (stall1 || stall2);
    assign rf.busy_vec  = busy;

    assign rf.rdata1 = rst ? '0 : read_mux(rf.re1, rf.raddr1, rf.we0, rf.waddr0, rf.wdata0,
                                           rf.we1, rf.waddr1, rf.wdata1, regs[rf.raddr1]);
    assign rf.rdata2 = rst ? '0 : read_mux(rf.re2, rf.raddr2, rf.we0, rf.waddr0, rf.wdata0,
                                           rf.we1, rf.waddr1, rf.wdata1, regs[rf.raddr2]);
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, async-reset sequence,
// and randomized traffic against a register/scoreboard reference model.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  waddr0;
        logic [31:0] wdata0;
        logic        we1;
        logic [4:0]  waddr1;
        logic [31:0] wdata1;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        exp_stall;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(
        input logic we0, input logic [4:0] a0, input logic [31:0] d0,
        input logic we1, input logic [4:0] a1, input logic [31:0] d1,
        input logic re1, input logic [4:0] r1, input logic re2, input logic [4:0] r2,
        input logic iss, input logic [4:0] ia,
        input logic [31:0] e1, input logic [31:0] e2, input logic es, input logic [31:0] eb
    );
        vec_t v;
        v.we0 = we0; v.waddr0 = a0; v.wdata0 = d0;
        v.we1 = we1; v.waddr1 = a1; v.wdata1 = d1;
        v.re1 = re1; v.raddr1 = r1; v.re2 = re2; v.raddr2 = r2;
        v.iss_en = iss; v.iss_addr = ia;
        v.exp1 = e1; v.exp2 = e2; v.exp_stall = es; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rf.we0 = v.we0; rf.waddr0 = v.waddr0; rf.wdata0 = v.wdata0;
        rf.we1 = v.we1; rf.waddr1 = v.waddr1; rf.wdata1 = v.wdata1;
        rf.re1 = v.re1; rf.raddr1 = v.raddr1; rf.re2 = v.re2; rf.raddr2 = v.raddr2;
        rf.iss_en = v.iss_en; rf.iss_addr = v.iss_addr;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference model state
    logic [31:0] mregs [DEPTH];
    logic [31:0] mbusy;

    initial begin
        logic [31:0] nxt [DEPTH];
        logic [31:0] wr;
        logic [31:0] e1, e2;
        logic        es;
        vec_t        v;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();

        // Outputs held at zero throughout reset, even with reads and writes requested.
        #2;
        drive(mk(1, 3, 32'h1234, 0, 0, 0, 1, 3, 1, 5, 1, 5, 0, 0, 0, 0));
        #1;
        chk("rst_rdata1", rf.rdata1, 0);
        chk("rst_stall", rf.stall_req, 0);
        @(posedge clk);
        #1;
        chk("rst_busy", rf.busy_vec, 0);
        idle();
        @(posedge clk);
        #1 rst = 1'b0;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tbl[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 32'h0);
        tbl[3]  = mk(1, 7, 32'h11, 1, 7, 32'h22, 1, 7, 1, 7, 0, 0, 32'h11, 32'h11, 0, 32'h0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 3, 0, 0, 32'h11, 32'hDEADBEEF, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9, 32'h0, 32'h0, 0, 32'h0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 32'h0, 1, 32'h200);
        tbl[7]  = mk(0, 0, 0, 1, 9, 32'h55, 0, 0, 1, 9, 0, 0, 32'h0, 32'h55, 0, 32'h200);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 32'h55, 0, 32'h0);
        tbl[9]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0, 32'h0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tbl[11] = mk(1, 12, 32'h77, 0, 0, 0, 1, 12, 0, 0, 1, 12, 32'h77, 32'h0, 0, 32'h0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 12, 0, 3, 0, 0, 32'h77, 32'h0, 1, 32'h1000);
        tbl[13] = mk(0, 0, 0, 1, 12, 32'h88, 1, 12, 0, 0, 0, 0, 32'h88, 32'h0, 0, 32'h1000);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 12, 1, 3, 0, 0, 32'h88, 32'hDEADBEEF, 0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            #3;
            chk($sformatf("tbl%0d_rdata1", i), rf.rdata1, tbl[i].exp1);
            chk($sformatf("tbl%0d_rdata2", i), rf.rdata2, tbl[i].exp2);
            chk($sformatf("tbl%0d_stall", i), rf.stall_req, tbl[i].exp_stall);
            chk($sformatf("tbl%0d_busy", i), rf.busy_vec, tbl[i].exp_busy);
            @(posedge clk);
            #1;
        end

        // Mid-cycle asynchronous reset wipes data and scoreboard without a clock edge.
        drive(mk(1, 4, 32'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 6, 0, 0, 0, 0, 0, 0));
        #2;
        chk("pre_rst_rdata1", rf.rdata1, 32'hAA);
        chk("pre_rst_stall", rf.stall_req, 1);
        chk("pre_rst_busy", rf.busy_vec, 32'h40);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rdata1", rf.rdata1, 0);
        chk("async_rst_stall", rf.stall_req, 0);
        chk("async_rst_busy", rf.busy_vec, 0);
        drive(mk(1, 4, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 6, 0, 0, 0, 0, 0, 0));
        #2;
        chk("post_rst_rdata1", rf.rdata1, 0);
        chk("post_rst_stall", rf.stall_req, 0);
        chk("post_rst_busy", rf.busy_vec, 0);
        @(posedge clk);
        #1;
        drive(mk(1, 4, 32'h99, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 6, 0, 0, 0, 0, 0, 0));
        #2;
        chk("first_write_rdata1", rf.rdata1, 32'h99);
        chk("first_issue_stall", rf.stall_req, 1);
        chk("first_issue_busy", rf.busy_vec, 32'h40);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) mregs[i] = '0;
        mbusy = '0;
        for (int c = 0; c < 400; c++) begin
            v.we0 = 1'($urandom_range(0, 1));
            v.we1 = 1'($urandom_range(0, 1));
            v.re1 = ($urandom_range(0, 3) != 0);
            v.re2 = ($urandom_range(0, 3) != 0);
            v.iss_en = 1'($urandom_range(0, 1));
            v.waddr0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.waddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.raddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.raddr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.iss_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.wdata0 = $urandom;
            v.wdata1 = $urandom;
            drive(v);

            // End-of-cycle register contents: port 1 first so port 0 overwrites on collision.
            for (int i = 0; i < DEPTH; i++) nxt[i] = mregs[i];
            wr = '0;
            if (v.we1 && v.waddr1 != 0) begin nxt[v.waddr1] = v.wdata1; wr[v.waddr1] = 1'b1; end
            if (v.we0 && v.waddr0 != 0) begin nxt[v.waddr0] = v.wdata0; wr[v.waddr0] = 1'b1; end

            e1 = (v.re1 && v.raddr1 != 0) ? (wr[v.raddr1] ? nxt[v.raddr1] : mregs[v.raddr1]) : 32'h0;
            e2 = (v.re2 && v.raddr2 != 0) ? (wr[v.raddr2] ? nxt[v.raddr2] : mregs[v.raddr2]) : 32'h0;
            es = (v.re1 && v.raddr1 != 0 && mbusy[v.raddr1] && !wr[v.raddr1]) ||
                 (v.re2 && v.raddr2 != 0 && mbusy[v.raddr2] && !wr[v.raddr2]);

            #3;
            chk($sformatf("rnd%0d_rdata1", c), rf.rdata1, e1);
            chk($sformatf("rnd%0d_rdata2", c), rf.rdata2, e2);
            chk($sformatf("rnd%0d_stall", c), rf.stall_req, es);
            chk($sformatf("rnd%0d_busy", c), rf.busy_vec, mbusy);

            for (int i = 0; i < DEPTH; i++) mregs[i] = nxt[i];
            mbusy = mbusy & ~wr;
            if (v.iss_en && v.iss_addr != 0) mbusy[v.iss_addr] = 1'b1;

            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
